// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the write-back request queue
package wb_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] WB_ADDR_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } wb_req_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// rtl/wb_write_queue_if.sv - producer, GRF write and bypass signals of the write-back queue
interface wb_write_queue_if #(parameter int DEPTH = 4);
  import wb_pkg::*;

  logic                     a_valid;
  logic [AW-1:0]            a_addr;
  logic [DW-1:0]            a_data;
  logic [DW-1:0]            a_pc;
  logic                     b_valid;
  logic [AW-1:0]            b_addr;
  logic [DW-1:0]            b_data;
  logic [DW-1:0]            b_pc;
  logic                     in_ready;
  logic                     wb_we;
  logic [AW-1:0]            wb_addr;
  logic [DW-1:0]            wb_data;
  logic [DW-1:0]            wb_pc;
  logic [AW-1:0]            q_addr1;
  logic [AW-1:0]            q_addr2;
  logic                     q_hit1;
  logic [DW-1:0]            q_data1;
  logic                     q_hit2;
  logic [DW-1:0]            q_data2;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  a_valid, a_addr, a_data, a_pc,
    input  b_valid, b_addr, b_data, b_pc,
    input  q_addr1, q_addr2,
    output in_ready, wb_we, wb_addr, wb_data, wb_pc,
    output q_hit1, q_data1, q_hit2, q_data2, count
  );

  modport master (
    output a_valid, a_addr, a_data, a_pc,
    output b_valid, b_addr, b_data, b_pc,
    output q_addr1, q_addr2,
    input  in_ready, wb_we, wb_addr, wb_data, wb_pc,
    input  q_hit1, q_data1, q_hit2, q_data2, count
  );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular buffer with 0/1/2 pushes and 0/1 pop per cycle
// Entries are exposed oldest-first so the bypass search can resolve age order.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             push_n,
  input  wb_req_t                push0,
  input  wb_req_t                push1,
  input  logic                   pop,
  output wb_req_t                head,
  output logic [$clog2(DEPTH):0] count,
  output wb_req_t                ent [DEPTH],
  output logic [DEPTH-1:0]       ent_valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  wb_req_t       mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push_n);
      count  <= count + CW'(push_n) - CW'(pop);
    end
  end

  // Storage needs no reset: an entry is only observed once count covers it.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr] <= push0;
    if (push_n == 2'd2) mem[wr_ptr + PW'(1)] <= push1;
  end

  always_comb begin
    head = mem[rd_ptr];
    for (int i = 0; i < DEPTH; i++) begin
      ent[i]       = mem[rd_ptr + PW'(i)];
      ent_valid[i] = (CW'(i) < count);
    end
  end
endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - merges two write-back producers into one ordered GRF write stream
// with a two-port bypass lookup over pending writes.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  wb_write_queue_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          a_ok, b_ok, pop;
  logic [1:0]    push_n;
  wb_req_t       a_req, b_req, slot0, head;
  logic [CW-1:0] count;
  wb_req_t       ent [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic          wb_we_r;
  wb_req_t       wb_r;

  assign bus.in_ready = (count <= CW'(DEPTH - 2));
  assign bus.count    = count;

  assign a_req = '{addr: bus.a_addr, data: bus.a_data, pc: bus.a_pc};
  assign b_req = '{addr: bus.b_addr, data: bus.b_data, pc: bus.b_pc};
  assign a_ok  = bus.a_valid && bus.in_ready && (bus.a_addr != WB_ADDR_ZERO);
  assign b_ok  = bus.b_valid && bus.in_ready && (bus.b_addr != WB_ADDR_ZERO);
  // Compact accepted requests so A always lands in the older slot.
  assign push_n = {1'b0, a_ok} + {1'b0, b_ok};
  assign slot0  = a_ok ? a_req : b_req;
  assign pop    = (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_n    (push_n),
    .push0     (slot0),
    .push1     (b_req),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .ent       (ent),
    .ent_valid (ent_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_we_r <= 1'b0;
      wb_r    <= '0;
    end else if (pop) begin
      wb_we_r <= 1'b1;
      wb_r    <= head;
    end else begin
      wb_we_r <= 1'b0;
    end
  end

  assign bus.wb_we   = wb_we_r;
  assign bus.wb_addr = wb_r.addr;
  assign bus.wb_data = wb_r.data;
  assign bus.wb_pc   = wb_r.pc;

  // Scan oldest to youngest so the last match (youngest) wins; {hit, data}.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] q);
    logic [DW:0] r;
    r = '0;
    if (wb_we_r && wb_r.addr == q) r = {1'b1, wb_r.data};
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i] && ent[i].addr == q) r = {1'b1, ent[i].data};
    if (q == WB_ADDR_ZERO) r = '0;
    return r;
  endfunction

  always_comb begin
    {bus.q_hit1, bus.q_data1} = lookup(bus.q_addr1);
    {bus.q_hit2, bus.q_data2} = lookup(bus.q_addr2);
  end
endmodule
